fetch_unit: RTL

- Instruction-fetch front end that sits directly upstream of the decode/execute datapath.
- Owns the architectural PC and issues word-aligned read requests to instruction memory.
- Buffers returned instructions, with their PCs, in a small FIFO.
- Hands instructions to decode over a valid/ready handshake. On a taken-branch/jump redirect from execute, flushes wrong-path work and restarts fetch at the target.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/fetch_unit_chk.sv | 26 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 106 ++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths and constants used by the fetch front end.
package cpu_pkg;
  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam logic [XLEN-1:0]    PC_STEP   = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_unit_chk.sv
// Invariants of the fetch credit scheme: live tags plus dropped responses equal in-flight requests.
module fetch_unit_chk #(
  parameter int CNT_W = 3
) (
  input logic             clk,
  input logic             rst,
  input logic [CNT_W-1:0] outstanding,
  input logic [CNT_W-1:0] drop,
  input logic [CNT_W-1:0] tag_count,
  input logic             tag_full,
  input logic             tag_empty,
  input logic             fifo_full,
  input logic             fifo_push,
  input logic             fifo_pop
);
  a_tag_balance: assert property (@(posedge clk) disable iff (rst)
    ((CNT_W+1)'(tag_count) + (CNT_W+1)'(drop)) == (CNT_W+1)'(outstanding));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full && !fifo_pop));
  a_credit: assert property (@(posedge clk) disable iff (rst)
    !(fifo_full && (outstanding != CNT_W'(0))));
  a_tag_full_live: assert property (@(posedge clk) disable iff (rst)
    tag_full |-> (drop == CNT_W'(0)));
  a_tag_present: assert property (@(posedge clk) disable iff (rst)
    fifo_push |-> !tag_empty);
endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; count is one bit wider than the pointers.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full     = (count_r == (PTR_W+1)'(DEPTH));
  assign empty    = (count_r == (PTR_W+1)'(0));
  assign count    = count_r;
  assign pop_data = mem_r[rd_ptr_r];

  // A push into a full FIFO is only taken when a pop frees the head slot.
  always_comb begin
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
  end

  // Storage, pointers and occupancy; flush discards every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r <= count_r + (PTR_W+1)'(push_ok_s) - (PTR_W+1)'(pop_ok_s);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues credit-limited memory reads and
// buffers returned words with their PCs for decode; redirects flush and restart fetch.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [XLEN-1:0]    out_pc
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]         pc_r;
  logic [CNT_W-1:0]        outstanding_r;
  logic [CNT_W-1:0]        drop_r;
  logic                    rst_q_r;
  logic [CNT_W-1:0]        fifo_count_s;
  logic [CNT_W-1:0]        tag_count_s;
  logic                    fifo_full_s, fifo_empty_s;
  logic                    tag_full_s, tag_empty_s;
  logic [XLEN-1:0]         tag_pc_s;
  logic [XLEN+INSTR_W-1:0] head_s;
  logic                    credit_ok_s, req_fire_s, rsp_keep_s, pop_s;

  // Outstanding requests and buffered entries together may never exceed DEPTH.
  assign credit_ok_s    = ({1'b0, outstanding_r} + {1'b0, fifo_count_s}) < (CNT_W+1)'(DEPTH);
  assign imem_req_valid = !rst_q_r && !redirect_valid && credit_ok_s;
  assign imem_addr      = pc_r;
  assign req_fire_s     = imem_req_valid && imem_req_ready;
  assign rsp_keep_s     = imem_rsp_valid && !redirect_valid && (drop_r == CNT_W'(0));
  assign pop_s          = !fifo_empty_s && out_ready && !redirect_valid;
  assign out_valid      = !fifo_empty_s;
  assign out_pc         = head_s[XLEN+INSTR_W-1:INSTR_W];
  assign out_instr      = head_s[INSTR_W-1:0];

  // PC, credit and drop bookkeeping; a redirect marks every in-flight response as dead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      outstanding_r <= '0;
      drop_r        <= '0;
      rst_q_r       <= 1'b1;
    end else begin
      rst_q_r       <= 1'b0;
      outstanding_r <= outstanding_r + CNT_W'(req_fire_s) - CNT_W'(imem_rsp_valid);
      if (redirect_valid) begin
        pc_r   <= align_pc(redirect_pc);
        drop_r <= outstanding_r - CNT_W'(imem_rsp_valid);
      end else begin
        if (req_fire_s) pc_r <= pc_r + PC_STEP;
        if (imem_rsp_valid && (drop_r != CNT_W'(0))) drop_r <= drop_r - CNT_W'(1);
      end
    end
  end

  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (req_fire_s),
    .push_data (pc_r),
    .pop       (rsp_keep_s),
    .pop_data  (tag_pc_s),
    .count     (tag_count_s),
    .full      (tag_full_s),
    .empty     (tag_empty_s)
  );

  sync_fifo #(.WIDTH(XLEN+INSTR_W), .DEPTH(DEPTH)) u_data_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_keep_s),
    .push_data ({tag_pc_s, imem_rsp_data}),
    .pop       (pop_s),
    .pop_data  (head_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  fetch_unit_chk #(.CNT_W(CNT_W)) u_chk (
    .clk         (clk),
    .rst         (rst),
    .outstanding (outstanding_r),
    .drop        (drop_r),
    .tag_count   (tag_count_s),
    .tag_full    (tag_full_s),
    .tag_empty   (tag_empty_s),
    .fifo_full   (fifo_full_s),
    .fifo_push   (rsp_keep_s),
    .fifo_pop    (pop_s)
  );
endmodule
